// File: rtl/sobel_pkg.sv
// sobel_pkg: shared types and helpers for the streaming Sobel edge detector.
//   sobel_mode_e : output mode (clamped magnitude or thresholded binary).
//   DEF_*        : default pixel width and image geometry.
//   ABS_W        : working width of sobel_abs; covers PIX_W + 3 for PIX_W up to 13.
//   sobel_abs    : absolute value of a signed ABS_W-bit value.
package sobel_pkg;

    typedef enum logic {
        SOBEL_MAG    = 1'b0,
        SOBEL_THRESH = 1'b1
    } sobel_mode_e;

    localparam int unsigned DEF_PIX_W = 8;
    localparam int unsigned DEF_IMG_W = 640;
    localparam int unsigned DEF_IMG_H = 480;

    localparam int unsigned ABS_W = 16;

    function automatic logic [ABS_W-1:0] sobel_abs(input logic signed [ABS_W-1:0] v);
        return v[ABS_W-1] ? unsigned'(-v) : unsigned'(v);
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: single-address line store holding two image rows side by side.
//   clk     : clock
//   we_i    : write enable
//   addr_i  : column address (shared by read and write)
//   wdata_i : {row r-1 pixel, new pixel} written at addr_i
//   rdata_o : {row r-2 pixel, row r-1 pixel} read from addr_i
// The read is combinational so the old word is seen in the same cycle the
// new word is written (read-before-write). Contents are never reset.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int unsigned PIX_W = DEF_PIX_W,
    parameter int unsigned DEPTH = DEF_IMG_W
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [2*PIX_W-1:0]       wdata_i,
    output logic [2*PIX_W-1:0]       rdata_o
);

    logic [2*PIX_W-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/sobel_stream.sv
// sobel_stream: streaming 3x3 Sobel edge detector with valid/ready handshakes.
//   clk, rst      : clock, asynchronous active-high reset
//   in_valid_i    : input pixel valid          in_ready_o  : pixel can be accepted
//   in_data_i     : unsigned input pixel       in_last_i   : last pixel of frame
//   mode_i        : 0 clamped magnitude, 1 threshold (sampled at pixel (0,0))
//   thresh_i      : threshold for mode 1 (sampled at pixel (0,0))
//   out_valid_o   : result valid               out_ready_i : downstream accepts
//   out_data_o    : result pixel               out_last_o  : last result of frame
//   frame_err_o   : one-cycle pulse on frame-length mismatch
// Pipeline: S1 window/position, S2 Gx/Gy, S3 output. One global enable stalls
// every stage while the output register is full and not being taken.
module sobel_stream
    import sobel_pkg::*;
#(
    parameter int unsigned PIX_W = DEF_PIX_W,
    parameter int unsigned IMG_W = DEF_IMG_W,
    parameter int unsigned IMG_H = DEF_IMG_H
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [PIX_W-1:0] in_data_i,
    input  logic             in_last_i,
    input  logic             mode_i,
    input  logic [PIX_W+2:0] thresh_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [PIX_W-1:0] out_data_o,
    output logic             out_last_o,
    output logic             frame_err_o
);

    localparam int unsigned ColW = $clog2(IMG_W);
    localparam int unsigned RowW = $clog2(IMG_H);
    localparam int unsigned GW   = PIX_W + 3;

    localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);
    localparam logic [ColW-1:0] ColTwo  = ColW'(2);
    localparam logic [RowW-1:0] RowTwo  = RowW'(2);

    // ------------------------------------------------------------------
    // Handshake and position tracking
    // ------------------------------------------------------------------
    logic en, accept;
    logic out_valid_q;

    assign en         = !out_valid_q || out_ready_i;
    assign in_ready_o = en;
    assign accept     = in_valid_i && en;

    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic            at_end, at_origin, interior;
    logic            frame_err_q, frame_err_d;

    assign at_end    = (col_q == ColLast) && (row_q == RowLast);
    assign at_origin = (col_q == '0) && (row_q == '0);
    assign interior  = (col_q >= ColTwo) && (row_q >= RowTwo);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            // Either a frame end (real or early) or the geometric end restarts at (0,0)
            if (in_last_i || at_end) begin
                col_d = '0;
                row_d = '0;
            end else if (col_q == ColLast) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Mismatch in either direction: early in_last, or geometric end without it
    assign frame_err_d = accept && (in_last_i != at_end);

    // ------------------------------------------------------------------
    // Line buffers: low half is row r-1, high half is row r-2
    // ------------------------------------------------------------------
    logic [2*PIX_W-1:0] lb_rdata;
    logic [PIX_W-1:0]   lb0_pix, lb1_pix;

    assign lb0_pix = lb_rdata[PIX_W-1:0];
    assign lb1_pix = lb_rdata[2*PIX_W-1:PIX_W];

    sobel_line_buffer #(
        .PIX_W (PIX_W),
        .DEPTH (IMG_W)
    ) u_line_buffer (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (col_q),
        .wdata_i ({lb0_pix, in_data_i}),
        .rdata_o (lb_rdata)
    );

    // ------------------------------------------------------------------
    // Frame-level mode/threshold, carried down the pipe with each pixel so
    // the tail of one frame is not affected by the head of the next.
    // ------------------------------------------------------------------
    sobel_mode_e      mode_q, cur_mode;
    logic [PIX_W+2:0] thresh_q, cur_thresh;

    always_comb begin
        cur_mode   = mode_q;
        cur_thresh = thresh_q;
        if (at_origin) begin
            cur_mode   = sobel_mode_e'(mode_i);
            cur_thresh = thresh_i;
        end
    end

    // ------------------------------------------------------------------
    // S1: 3x3 window, row 0 = top (r-2), column 2 = newest
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] win_q [3][3];

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb1_pix;
            win_q[1][2] <= lb0_pix;
            win_q[2][2] <= in_data_i;
        end
    end

    logic             s1_valid_q, s1_last_q;
    sobel_mode_e      s1_mode_q;
    logic [PIX_W+2:0] s1_thresh_q;

    // ------------------------------------------------------------------
    // S2: gradients from the window
    // ------------------------------------------------------------------
    function automatic logic [GW-1:0] ext(input logic [PIX_W-1:0] p);
        return {3'b000, p};
    endfunction

    logic [GW-1:0]        col_l, col_r, row_t, row_b;
    logic signed [GW-1:0] gx_d, gy_d;

    always_comb begin
        col_l = ext(win_q[0][0]) + (ext(win_q[1][0]) << 1) + ext(win_q[2][0]);
        col_r = ext(win_q[0][2]) + (ext(win_q[1][2]) << 1) + ext(win_q[2][2]);
        row_t = ext(win_q[0][0]) + (ext(win_q[0][1]) << 1) + ext(win_q[0][2]);
        row_b = ext(win_q[2][0]) + (ext(win_q[2][1]) << 1) + ext(win_q[2][2]);
        // Each weighted sum is at most 4*(2^PIX_W-1), so the difference fits GW signed
        gx_d  = signed'(col_r - col_l);
        gy_d  = signed'(row_t - row_b);
    end

    logic signed [GW-1:0] gx_q, gy_q;
    logic                 s2_valid_q, s2_last_q;
    sobel_mode_e          s2_mode_q;
    logic [PIX_W+2:0]     s2_thresh_q;

    // ------------------------------------------------------------------
    // S3: magnitude and mode-dependent output
    // ------------------------------------------------------------------
    logic signed [ABS_W-1:0] gx_ext, gy_ext;
    logic [ABS_W-1:0]        mag;
    logic [PIX_W-1:0]        out_data_d;

    always_comb begin
        gx_ext = ABS_W'(gx_q);
        gy_ext = ABS_W'(gy_q);
        mag    = sobel_abs(gx_ext) + sobel_abs(gy_ext);
        if (s2_mode_q == SOBEL_THRESH) begin
            out_data_d = (mag > {{(ABS_W-PIX_W-3){1'b0}}, s2_thresh_q}) ? '1 : '0;
        end else begin
            out_data_d = (|mag[ABS_W-1:PIX_W]) ? '1 : mag[PIX_W-1:0];
        end
    end

    logic [PIX_W-1:0] out_data_q;
    logic             out_last_q;

    // ------------------------------------------------------------------
    // Control and pipeline state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            frame_err_q <= 1'b0;
            mode_q      <= SOBEL_MAG;
            thresh_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_mode_q   <= SOBEL_MAG;
            s1_thresh_q <= '0;
            gx_q        <= '0;
            gy_q        <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_mode_q   <= SOBEL_MAG;
            s2_thresh_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            frame_err_q <= frame_err_d;
            if (accept && at_origin) begin
                mode_q   <= cur_mode;
                thresh_q <= cur_thresh;
            end
            if (en) begin
                s1_valid_q  <= accept && interior;
                s1_last_q   <= accept && at_end;
                s1_mode_q   <= cur_mode;
                s1_thresh_q <= cur_thresh;

                gx_q        <= gx_d;
                gy_q        <= gy_d;
                s2_valid_q  <= s1_valid_q;
                s2_last_q   <= s1_last_q;
                s2_mode_q   <= s1_mode_q;
                s2_thresh_q <= s1_thresh_q;

                out_valid_q <= s2_valid_q;
                out_data_q  <= out_data_d;
                out_last_q  <= s2_valid_q && s2_last_q;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_sobel_stream.sv
module tb_sobel_stream;

    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last, mode;
    logic [7:0]  in_data;
    logic [10:0] thresh;
    logic        out_valid, out_ready, out_last, frame_err;
    logic [7:0]  out_data;

    always #5 clk = ~clk;

    sobel_stream #(
        .PIX_W (8),
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .mode_i      (mode),
        .thresh_i    (thresh),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .frame_err_o (frame_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int img [N];
    int exp_d [$];
    bit exp_l [$];
    int got_d [$];
    bit got_l [$];
    int err_cnt = 0;

    // Reference: Sobel over the first n raster pixels of img, straight from the definition
    function automatic void model(input int n, input bit md, input int th);
        int r, c, gx, gy, mag, v, wt;
        for (int k = 0; k < n; k++) begin
            r = k / W;
            c = k % W;
            if (r >= 2 && c >= 2) begin
                gx = 0;
                gy = 0;
                for (int i = 0; i < 3; i++) begin
                    wt = (i == 1) ? 2 : 1;
                    gx += wt * (img[(r - 2 + i) * W + c] - img[(r - 2 + i) * W + c - 2]);
                    gy += wt * (img[(r - 2) * W + c - 2 + i] - img[r * W + c - 2 + i]);
                end
                mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                if (md) v = (mag > th) ? 255 : 0;
                else    v = (mag > 255) ? 255 : mag;
                exp_d.push_back(v);
                exp_l.push_back(k == N - 1);
            end
        end
    endfunction

    // Stream img[0..n-1]; in_last on last_idx (-1 for none). Optionally drain outputs.
    task automatic send(input int n, input int last_idx, input bit md, input int th,
                        input int vpct, input int rpct, input bit drain);
        int i = 0;
        int idle = 0;
        int cyc = 0;
        bit hold = 0;
        logic [7:0] hd;
        logic hl;
        while ((i < n || (drain && idle < 6)) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== hd || out_last !== hl) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%b d=%0d l=%b, want v=1 d=%0d l=%b",
                             out_valid, out_data, out_last, hd, hl);
                end
            end
            in_valid = (i < n) && ($urandom_range(99) < vpct);
            in_data  = (i < n) ? 8'(img[i]) : 8'd0;
            in_last  = (i == last_idx);
            if (i == 0) begin
                mode   = md;
                thresh = 11'(th);
            end else begin
                mode   = 1'($urandom_range(1));
                thresh = 11'($urandom);
            end
            out_ready = ($urandom_range(99) < rpct);
            #1;
            hold = out_valid && !out_ready;
            if (hold) begin
                hd = out_data;
                hl = out_last;
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_in_ready: got %b, want 0", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                got_d.push_back(int'(out_data));
                got_l.push_back(out_last);
            end
            if (frame_err) err_cnt++;
            if (in_valid && in_ready) begin
                i++;
                idle = 0;
            end else if (i >= n) begin
                idle = out_valid ? 0 : idle + 1;
            end
        end
        if (cyc >= 3000) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: accepted %0d of %0d pixels", i, n);
        end
        if (drain) in_valid = 1'b0;
    endtask

    task automatic clear_queues();
        exp_d.delete();
        exp_l.delete();
        got_d.delete();
        got_l.delete();
        err_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'd0 ||
            out_last !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b v=%b d=%0d l=%b e=%b, want 1 0 0 0 0",
                     in_ready, out_valid, out_data, out_last, frame_err);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_constant();
        clear_queues();
        for (int k = 0; k < N; k++) img[k] = 100;
        model(N, 1'b0, 0);
        send(N, N - 1, 1'b0, 0, 100, 100, 1'b1);
        n_checks++;
        if (got_d.size() != exp_d.size()) begin
            n_fail++;
            $display("FAIL const_count: got %0d, want %0d", got_d.size(), exp_d.size());
        end
        for (int k = 0; k < got_d.size() && k < exp_d.size(); k++) begin
            n_checks++;
            if (got_d[k] != exp_d[k] || got_l[k] != exp_l[k]) begin
                n_fail++;
                $display("FAIL const_px%0d: got %0d/%b, want %0d/%b",
                         k, got_d[k], got_l[k], exp_d[k], exp_l[k]);
            end
        end
        n_checks++;
        if (err_cnt != 0) begin
            n_fail++;
            $display("FAIL const_frame_err: got %0d pulses, want 0", err_cnt);
        end
    endtask

    task automatic test_step(input int rpct);
        clear_queues();
        for (int k = 0; k < N; k++) img[k] = (k % W < 4) ? 0 : 255;
        model(N, 1'b0, 0);
        send(N, N - 1, 1'b0, 0, 100, rpct, 1'b1);
        n_checks++;
        if (got_d.size() != exp_d.size()) begin
            n_fail++;
            $display("FAIL step_count(r%0d): got %0d, want %0d", rpct, got_d.size(), exp_d.size());
        end
        for (int k = 0; k < got_d.size() && k < exp_d.size(); k++) begin
            n_checks++;
            if (got_d[k] != exp_d[k] || got_l[k] != exp_l[k]) begin
                n_fail++;
                $display("FAIL step_px%0d(r%0d): got %0d/%b, want %0d/%b",
                         k, rpct, got_d[k], got_l[k], exp_d[k], exp_l[k]);
            end
        end
    endtask

    task automatic test_threshold(input int th);
        clear_queues();
        for (int k = 0; k < N; k++) img[k] = 10 * (k % W);
        model(N, 1'b1, th);
        send(N, N - 1, 1'b1, th, 100, 100, 1'b1);
        n_checks++;
        if (got_d.size() != exp_d.size()) begin
            n_fail++;
            $display("FAIL thr_count(t%0d): got %0d, want %0d", th, got_d.size(), exp_d.size());
        end
        for (int k = 0; k < got_d.size() && k < exp_d.size(); k++) begin
            n_checks++;
            if (got_d[k] != exp_d[k] || got_l[k] != exp_l[k]) begin
                n_fail++;
                $display("FAIL thr_px%0d(t%0d): got %0d/%b, want %0d/%b",
                         k, th, got_d[k], got_l[k], exp_d[k], exp_l[k]);
            end
        end
    endtask

    task automatic test_frame_err();
        // Early in_last at (2,3), then a full frame, then a frame missing in_last
        clear_queues();
        for (int k = 0; k < N; k++) img[k] = $urandom_range(255);
        model(2 * W + 4, 1'b0, 0);
        send(2 * W + 4, 2 * W + 3, 1'b0, 0, 90, 80, 1'b1);
        n_checks++;
        if (err_cnt != 1) begin
            n_fail++;
            $display("FAIL early_last_err: got %0d pulses, want 1", err_cnt);
        end
        model(N, 1'b0, 0);
        send(N, N - 1, 1'b0, 0, 90, 80, 1'b1);
        model(N, 1'b0, 0);
        send(N, -1, 1'b0, 0, 90, 80, 1'b1);
        n_checks++;
        if (err_cnt != 2) begin
            n_fail++;
            $display("FAIL missing_last_err: got %0d total pulses, want 2", err_cnt);
        end
        n_checks++;
        if (got_d.size() != exp_d.size()) begin
            n_fail++;
            $display("FAIL ferr_count: got %0d, want %0d", got_d.size(), exp_d.size());
        end
        for (int k = 0; k < got_d.size() && k < exp_d.size(); k++) begin
            n_checks++;
            if (got_d[k] != exp_d[k] || got_l[k] != exp_l[k]) begin
                n_fail++;
                $display("FAIL ferr_px%0d: got %0d/%b, want %0d/%b",
                         k, got_d[k], got_l[k], exp_d[k], exp_l[k]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_queues();
        for (int k = 0; k < N; k++) img[k] = 5 * k;
        send(3 * W + 6, -1, 1'b0, 0, 100, 100, 1'b0);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'd0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_clear: got v=%b d=%0d l=%b rdy=%b, want 0 0 0 1",
                     out_valid, out_data, out_last, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_queues();
        model(N, 1'b0, 0);
        send(N, N - 1, 1'b0, 0, 100, 100, 1'b1);
        n_checks++;
        if (got_d.size() != exp_d.size() || err_cnt != 0) begin
            n_fail++;
            $display("FAIL midreset_count: got %0d outs %0d errs, want %0d outs 0 errs",
                     got_d.size(), err_cnt, exp_d.size());
        end
        for (int k = 0; k < got_d.size() && k < exp_d.size(); k++) begin
            n_checks++;
            if (got_d[k] != exp_d[k] || got_l[k] != exp_l[k]) begin
                n_fail++;
                $display("FAIL midreset_px%0d: got %0d/%b, want %0d/%b",
                         k, got_d[k], got_l[k], exp_d[k], exp_l[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit md;
        int th;
        clear_queues();
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < N; k++) img[k] = $urandom_range(255);
            md = 1'($urandom_range(1));
            th = $urandom_range(600);
            model(N, md, th);
            send(N, N - 1, md, th, 85, 75, f == 3);
        end
        n_checks++;
        if (got_d.size() != exp_d.size() || err_cnt != 0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d outs %0d errs, want %0d outs 0 errs",
                     got_d.size(), err_cnt, exp_d.size());
        end
        for (int k = 0; k < got_d.size() && k < exp_d.size(); k++) begin
            n_checks++;
            if (got_d[k] != exp_d[k] || got_l[k] != exp_l[k]) begin
                n_fail++;
                $display("FAIL b2b_px%0d: got %0d/%b, want %0d/%b",
                         k, got_d[k], got_l[k], exp_d[k], exp_l[k]);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        in_last   = 1'b0;
        mode      = 1'b0;
        thresh    = 11'd0;
        out_ready = 1'b1;
        test_reset();
        test_constant();
        test_step(100);
        test_threshold(79);
        test_threshold(80);
        test_step(50);
        test_frame_err();
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
